// File: rtl/vga_mem_bram_responder.sv
// Block-RAM responder for the VGA VRAM request port: in-order request FIFO, execute stage,
// one-cycle array read and show-ahead read-return FIFO. Optional VGA_MEM_RESP_RANGE_CHECK_EN.
module vga_mem_bram_responder #(
  parameter int P_ADDR_W    = 16,
  parameter int P_CMD_DEPTH = 4,
  parameter int P_RET_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iREQ_VALID,
  input  logic        iREQ_RW,
  input  logic [1:0]  iREQ_BYTEENA,
  input  logic [31:0] iREQ_ADDR,
  input  logic [15:0] iREQ_DATA,
  output logic        oREQ_BUSY,
  output logic        oRD_VALID,
  output logic [15:0] oRD_DATA,
  input  logic        iRD_BUSY,
  output logic        oRANGE_ERR
);
  // Handshakes: a request transfers on an edge with iREQ_VALID && !oREQ_BUSY; read data
  // transfers on an edge with oRD_VALID && !iRD_BUSY, and holds steady while iRD_BUSY is high.
  localparam int CMD_AW = $clog2(P_CMD_DEPTH);
  localparam int RET_AW = $clog2(P_RET_DEPTH);
  localparam logic [CMD_AW:0]   CMD_FULL  = (CMD_AW+1)'(P_CMD_DEPTH);
  localparam logic [RET_AW+1:0] RET_LIMIT = (RET_AW+2)'(P_RET_DEPTH);

  typedef struct packed {
    logic        rw;
    logic [1:0]  byteena;
    logic [31:0] addr;
    logic [15:0] data;
  } cmd_t;

  cmd_t              cmd_mem [P_CMD_DEPTH];
  logic [CMD_AW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CMD_AW:0]   cmd_count;
  cmd_t              cmd_head;
  logic              cmd_push, cmd_pop, cmd_empty;

  logic [15:0]         ram [2**P_ADDR_W];
  logic [P_ADDR_W-1:0] exec_idx;
  logic                in_range, credit_ok, exec_wr, exec_rd;
  logic                mem_stage_valid;
  logic [15:0]         mem_data;

  logic [15:0]       ret_mem [P_RET_DEPTH];
  logic [RET_AW-1:0] ret_wr_ptr, ret_rd_ptr;
  logic [RET_AW:0]   ret_count;
  logic [RET_AW+1:0] ret_used;
  logic              ret_push, ret_pop, ret_empty;

  assign cmd_empty = (cmd_count == '0);
  assign oREQ_BUSY = (cmd_count == CMD_FULL);
  assign cmd_push  = iREQ_VALID && !oREQ_BUSY;
  assign cmd_head  = cmd_mem[cmd_rd_ptr];
  assign exec_idx  = cmd_head.addr[P_ADDR_W-1:0];

  // A read may only leave the FIFO when the return path has a guaranteed slot for it.
  assign ret_used  = {1'b0, ret_count} + {{(RET_AW+1){1'b0}}, mem_stage_valid};
  assign credit_ok = (ret_used < RET_LIMIT);
  assign cmd_pop   = !cmd_empty && !iRESET_SYNC && (cmd_head.rw || credit_ok);
  assign exec_wr   = cmd_pop && cmd_head.rw && in_range;
  assign exec_rd   = cmd_pop && !cmd_head.rw;

  assign ret_push  = mem_stage_valid;
  assign ret_empty = (ret_count == '0);
  assign oRD_VALID = !ret_empty;
  assign oRD_DATA  = ret_empty ? 16'h0000 : ret_mem[ret_rd_ptr];
  assign ret_pop   = oRD_VALID && !iRD_BUSY;

`ifdef VGA_MEM_RESP_RANGE_CHECK_EN
  logic range_err;
  assign in_range   = (cmd_head.addr[31:P_ADDR_W] == '0);
  assign oRANGE_ERR = range_err;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      range_err <= 1'b0;
    end else if (iRESET_SYNC) begin
      range_err <= 1'b0;
    end else if (cmd_pop && !in_range) begin
      range_err <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;
  assign in_range       = 1'b1;
  assign unused_addr_hi = ^cmd_head.addr[31:P_ADDR_W];
  assign oRANGE_ERR     = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cmd_wr_ptr      <= '0;
      cmd_rd_ptr      <= '0;
      cmd_count       <= '0;
      ret_wr_ptr      <= '0;
      ret_rd_ptr      <= '0;
      ret_count       <= '0;
      mem_stage_valid <= 1'b0;
    end else if (iRESET_SYNC) begin
      cmd_wr_ptr      <= '0;
      cmd_rd_ptr      <= '0;
      cmd_count       <= '0;
      ret_wr_ptr      <= '0;
      ret_rd_ptr      <= '0;
      ret_count       <= '0;
      mem_stage_valid <= 1'b0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
      if (ret_push) ret_wr_ptr <= ret_wr_ptr + 1'b1;
      if (ret_pop)  ret_rd_ptr <= ret_rd_ptr + 1'b1;
      case ({ret_push, ret_pop})
        2'b10:   ret_count <= ret_count + 1'b1;
        2'b01:   ret_count <= ret_count - 1'b1;
        default: ret_count <= ret_count;
      endcase
      mem_stage_valid <= exec_rd;
    end
  end

  // Storage has no reset: reset flushes pointers only, array contents survive.
  always_ff @(posedge iCLOCK) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr] <= '{rw: iREQ_RW, byteena: iREQ_BYTEENA, addr: iREQ_ADDR, data: iREQ_DATA};
    end
    if (ret_push) begin
      ret_mem[ret_wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (exec_wr) begin
      if (cmd_head.byteena[0]) ram[exec_idx][7:0]  <= cmd_head.data[7:0];
      if (cmd_head.byteena[1]) ram[exec_idx][15:8] <= cmd_head.data[15:8];
    end
    if (exec_rd) begin
      mem_data <= in_range ? ram[exec_idx] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_vga_mem_bram_responder.sv
// Self-checking bench for vga_mem_bram_responder: reset values, vector table, latency,
// back-pressure, sync reset flush, address range handling and a randomized run.
module tb_vga_mem_bram_responder;
  localparam int P_ADDR_W    = 16;
  localparam int P_CMD_DEPTH = 4;
  localparam int P_RET_DEPTH = 4;
`ifdef VGA_MEM_RESP_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iREQ_VALID = 1'b0;
  logic        iREQ_RW = 1'b0;
  logic [1:0]  iREQ_BYTEENA = 2'b00;
  logic [31:0] iREQ_ADDR = '0;
  logic [15:0] iREQ_DATA = '0;
  logic        oREQ_BUSY, oRD_VALID, oRANGE_ERR;
  logic [15:0] oRD_DATA;
  logic        iRD_BUSY = 1'b0;

  always #5 clk = ~clk;

  vga_mem_bram_responder #(
    .P_ADDR_W(P_ADDR_W), .P_CMD_DEPTH(P_CMD_DEPTH), .P_RET_DEPTH(P_RET_DEPTH)
  ) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(iRESET_SYNC),
    .iREQ_VALID(iREQ_VALID), .iREQ_RW(iREQ_RW), .iREQ_BYTEENA(iREQ_BYTEENA),
    .iREQ_ADDR(iREQ_ADDR), .iREQ_DATA(iREQ_DATA), .oREQ_BUSY(oREQ_BUSY),
    .oRD_VALID(oRD_VALID), .oRD_DATA(oRD_DATA), .iRD_BUSY(iRD_BUSY),
    .oRANGE_ERR(oRANGE_ERR)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int accepted_rd = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [int];

  typedef struct {
    logic        rw;
    logic [1:0]  be;
    logic [31:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a[31:P_ADDR_W] == '0) || !RANGE_CHK;
  endfunction

  // Array model: byte-masked writes, reads return current contents or zero when out of range.
  task automatic model_accept(input logic rw, input logic [1:0] be, input logic [31:0] addr,
                              input logic [15:0] data, input bit use_exp, input logic [15:0] exp);
    int idx;
    logic [15:0] old;
    idx = int'(addr[P_ADDR_W-1:0]);
    if (rw) begin
      if (model_in_range(addr)) begin
        old = ref_mem.exists(idx) ? ref_mem[idx] : 16'h0000;
        ref_mem[idx] = {be[1] ? data[15:8] : old[15:8], be[0] ? data[7:0] : old[7:0]};
      end
    end else begin
      accepted_rd++;
      if (use_exp) exp_q.push_back(exp);
      else if (!model_in_range(addr)) exp_q.push_back(16'h0000);
      else exp_q.push_back(ref_mem.exists(idx) ? ref_mem[idx] : 16'h0000);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input logic rw, input logic [1:0] be, input logic [31:0] addr,
                      input logic [15:0] data, input bit use_exp, input logic [15:0] exp);
    int waited = 0;
    iREQ_VALID = 1'b1; iREQ_RW = rw; iREQ_BYTEENA = be; iREQ_ADDR = addr; iREQ_DATA = data;
    while (oREQ_BUSY && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (oREQ_BUSY) begin
      check("req_accept_timeout", {31'd0, oREQ_BUSY}, 32'd0);
      iREQ_VALID = 1'b0;
    end else begin
      @(posedge clk); #1;
      model_accept(rw, be, addr, data, use_exp, exp);
    end
  endtask

  task automatic idle();
    iREQ_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic monitor();
    logic hold_prev = 1'b0;
    logic rst_prev = 1'b1;
    logic [15:0] data_prev = '0;
    forever begin
      @(negedge clk);
      if (hold_prev && !rst_prev) begin
        check("hold_valid", {31'd0, oRD_VALID}, 32'd1);
        check("hold_data", {16'd0, oRD_DATA}, {16'd0, data_prev});
      end
      if (oRD_VALID && !iRD_BUSY && !iRESET_SYNC && rst_n) begin
        if (exp_q.size() == 0) check("unexpected_rd_valid", {31'd0, oRD_VALID}, 32'd0);
        else check("rd_data", {16'd0, oRD_DATA}, {16'd0, exp_q.pop_front()});
      end
      hold_prev = oRD_VALID && iRD_BUSY;
      data_prev = oRD_DATA;
      rst_prev  = iRESET_SYNC || !rst_n;
    end
  endtask

  initial begin
    bit rnd_done;
    int base_rd;
    vecs[0]  = '{1'b1, 2'b11, 32'h10, 16'hA5C3, 16'h0000};
    vecs[1]  = '{1'b0, 2'b00, 32'h10, 16'h0000, 16'hA5C3};
    vecs[2]  = '{1'b1, 2'b11, 32'h20, 16'h1234, 16'h0000};
    vecs[3]  = '{1'b1, 2'b01, 32'h20, 16'hFF00, 16'h0000};
    vecs[4]  = '{1'b0, 2'b00, 32'h20, 16'h0000, 16'h1200};
    vecs[5]  = '{1'b1, 2'b00, 32'h20, 16'h9876, 16'h0000};
    vecs[6]  = '{1'b0, 2'b00, 32'h20, 16'h0000, 16'h1200};
    vecs[7]  = '{1'b1, 2'b11, 32'h30, 16'hBEEF, 16'h0000};
    vecs[8]  = '{1'b0, 2'b00, 32'h30, 16'h0000, 16'hBEEF};
    vecs[9]  = '{1'b1, 2'b10, 32'h30, 16'h11AA, 16'h0000};
    vecs[10] = '{1'b0, 2'b00, 32'h30, 16'h0000, 16'h11EF};

    fork
      monitor();
      begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_busy", {31'd0, oREQ_BUSY}, 32'd0);
    check("rst_rd_valid", {31'd0, oRD_VALID}, 32'd0);
    check("rst_rd_data", {16'd0, oRD_DATA}, 32'd0);
    check("rst_range_err", {31'd0, oRANGE_ERR}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 64; a++) send(1'b1, 2'b11, a, 16'($urandom_range(0, 65535)), 1'b0, 16'h0);
    idle();

    for (int i = 0; i < 11; i++) send(vecs[i].rw, vecs[i].be, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].exp);
    idle();
    wait_drain();

    // Minimum read latency: valid appears in the cycle after the second edge past acceptance
    send(1'b0, 2'b00, 32'h10, 16'h0, 1'b1, 16'hA5C3);
    idle();
    @(negedge clk); check("lat_cycle1_valid", {31'd0, oRD_VALID}, 32'd0);
    @(negedge clk); check("lat_cycle2_valid", {31'd0, oRD_VALID}, 32'd0);
    @(negedge clk); check("lat_cycle3_valid", {31'd0, oRD_VALID}, 32'd1);
    check("lat_cycle3_data", {16'd0, oRD_DATA}, 32'hA5C3);
    @(posedge clk); #1;
    wait_drain();

    // Back-pressure with return path blocked
    for (int a = 0; a < 10; a++) send(1'b1, 2'b11, a, 16'(a), 1'b0, 16'h0);
    idle();
    @(posedge clk); #1;
    iRD_BUSY = 1'b1;
    base_rd = accepted_rd;
    fork
      for (int a = 0; a < 10; a++) send(1'b0, 2'b00, a, 16'h0, 1'b0, 16'h0);
      begin
        repeat (25) begin @(posedge clk); #1; end
        check("bp_req_busy", {31'd0, oREQ_BUSY}, 32'd1);
        check("bp_accepted_le_limit", {31'd0, (accepted_rd - base_rd) <= P_CMD_DEPTH + P_RET_DEPTH}, 32'd1);
        check("bp_rd_valid", {31'd0, oRD_VALID}, 32'd1);
        check("bp_rd_data", {16'd0, oRD_DATA}, 32'h0000);
        iRD_BUSY = 1'b0;
      end
    join
    idle();
    wait_drain();
    check("bp_reads_total", accepted_rd - base_rd, 10);

    // Synchronous reset with reads outstanding
    iRD_BUSY = 1'b1;
    for (int a = 0; a < 3; a++) send(1'b0, 2'b00, a, 16'h0, 1'b0, 16'h0);
    idle();
    iRESET_SYNC = 1'b1;
    @(posedge clk); #1;
    iRESET_SYNC = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("srst_rd_valid", {31'd0, oRD_VALID}, 32'd0);
    check("srst_req_busy", {31'd0, oREQ_BUSY}, 32'd0);
    check("srst_rd_data", {16'd0, oRD_DATA}, 32'd0);
    @(posedge clk); #1;
    iRD_BUSY = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("srst_range_err", {31'd0, oRANGE_ERR}, 32'd0);
    send(1'b0, 2'b00, 32'h10, 16'h0, 1'b1, 16'hA5C3);
    idle();
    wait_drain();

    // Address above the array
    send(1'b1, 2'b11, 32'h0001_0010, 16'h5555, 1'b0, 16'h0);
    send(1'b0, 2'b00, 32'h10, 16'h0, 1'b1, RANGE_CHK ? 16'hA5C3 : 16'h5555);
    idle();
    wait_drain();
    check("range_err_flag", {31'd0, oRANGE_ERR}, {31'd0, RANGE_CHK});

    // Randomized traffic against the array model
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] addr;
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk); #1;
          end
          addr[15:0]  = 16'($urandom_range(0, 63));
          addr[31:16] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
          send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), addr,
               16'($urandom_range(0, 65535)), 1'b0, 16'h0);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          iRD_BUSY = ($urandom_range(0, 3) == 0);
        end
        iRD_BUSY = 1'b0;
      end
    join
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
